trigger_capture_buf: RTL and testbench

//  Parametrised acquisition buffer for the oscilloscope path: stores a continuous
//  ADC sample stream in a circular RAM, detects a level/edge trigger and freezes a

---
 rtl/trigger_pkg.sv | 19 +
 rtl/trigger_detect.sv | 48 ++++
 rtl/trigger_capture_buf.sv | 179 +++++++++++++++++
 tb/tb_trigger_capture_buf.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared types for the oscilloscope trigger/capture buffer.
package trigger_pkg;

    typedef enum logic [1:0] {
        TRIG_RISE  = 2'b00,
        TRIG_FALL  = 2'b01,
        TRIG_EDGE  = 2'b10,
        TRIG_FORCE = 2'b11
    } trig_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/trigger_detect.sv
// Level-crossing trigger detector: remembers the previous valid sample since arm
// and raises a single-cycle hit on the qualifying valid sample.
module trigger_detect
    import trigger_pkg::*;
#(
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DATA_W-1:0] trig_level,
    input  trig_mode_t        mode,
    output logic              hit
);

    logic [DATA_W-1:0] prev_q;
    logic              prev_vld_q;
    logic              rise, fall, edge_hit;

    // clr wins over s_valid so a sample arriving with arm never becomes "prev"
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (s_valid) begin
            prev_q     <= s_data;
            prev_vld_q <= 1'b1;
        end
    end

    always_comb begin
        rise     = (prev_q <  trig_level) && (s_data >= trig_level);
        fall     = (prev_q >= trig_level) && (s_data <  trig_level);
        edge_hit = 1'b0;
        unique case (mode)
            TRIG_RISE:  edge_hit = prev_vld_q && rise;
            TRIG_FALL:  edge_hit = prev_vld_q && fall;
            TRIG_EDGE:  edge_hit = prev_vld_q && (rise || fall);
            TRIG_FORCE: edge_hit = 1'b1;
            default:    edge_hit = 1'b0;
        endcase
        hit = en && s_valid && edge_hit;
    end

endmodule

// File: rtl/trigger_capture_buf.sv
// Circular acquisition buffer with pre-trigger record freeze and ordered readout.
// Optional timeout auto-trigger is built when AUTO_TRIG_EN is defined.
module trigger_capture_buf
    import trigger_pkg::*;
#(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
`ifdef AUTO_TRIG_EN
    ,
    parameter int unsigned AUTO_TMO = 1 << 20
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W-1:0] pretrig,
    output logic              ready,
    output logic              busy,
    output logic              triggered,
    output logic              auto_trig,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    cap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pretrig_q, pretrig_d;
    logic              triggered_q, triggered_d;
    logic              auto_q, auto_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] rd_phys;
    logic              we, arm_ok, det_hit, auto_fire, trig_fire;

    logic [DATA_W-1:0] mem [DEPTH];

    assign arm_ok = arm && ((state_q == IDLE) || (state_q == DONE));

    trigger_detect #(
        .DATA_W (DATA_W)
    ) u_detect (
        .clk        (clk),
        .rst        (rst),
        .clr        (arm_ok),
        .en         (state_q == WAIT_TRIG),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .trig_level (trig_level),
        .mode       (trig_mode_t'(trig_mode)),
        .hit        (det_hit)
    );

`ifdef AUTO_TRIG_EN
    localparam int unsigned TMO_W = $clog2(AUTO_TMO + 1);
    logic [TMO_W-1:0] tmo_q;

    // held at zero outside WAIT_TRIG, so it restarts on every entry
    always_ff @(posedge clk) begin
        if (rst || (state_q != WAIT_TRIG)) begin
            tmo_q <= '0;
        end else if (tmo_q != TMO_W'(AUTO_TMO)) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign auto_fire = (tmo_q == TMO_W'(AUTO_TMO));
`else
    assign auto_fire = 1'b0;
`endif

    assign trig_fire = s_valid && (det_hit || auto_fire);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        cnt_d       = cnt_q;
        pretrig_d   = pretrig_q;
        triggered_d = triggered_q;
        auto_d      = auto_q;
        we          = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    pretrig_d   = pretrig;
                    cnt_d       = '0;
                    triggered_d = 1'b0;
                    auto_d      = 1'b0;
                    state_d     = (pretrig == '0) ? WAIT_TRIG : PREFILL;
                end
            end
            PREFILL: begin
                if (s_valid) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == pretrig_q - ADDR_W'(1)) begin
                        state_d = WAIT_TRIG;
                    end
                end
            end
            WAIT_TRIG: begin
                if (s_valid) begin
                    we = 1'b1;
                    if (trig_fire) begin
                        start_ptr_d = wr_ptr_q - pretrig_q;
                        triggered_d = 1'b1;
                        auto_d      = auto_fire && !det_hit;
                        cnt_d       = '0;
                        state_d     = (pretrig_q == ADDR_W'(DEPTH - 1)) ? DONE : POST;
                    end
                end
            end
            POST: begin
                if (s_valid) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(DEPTH - 2) - pretrig_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (we) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            cnt_q       <= '0;
            pretrig_q   <= '0;
            triggered_q <= 1'b0;
            auto_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            cnt_q       <= cnt_d;
            pretrig_q   <= pretrig_d;
            triggered_q <= triggered_d;
            auto_q      <= auto_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    assign rd_phys = start_ptr_q + rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_phys];
        end
    end

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == PREFILL) || (state_q == WAIT_TRIG) || (state_q == POST);
    assign triggered = triggered_q;
    assign auto_trig = auto_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_trigger_capture_buf.sv
// Bench for trigger_capture_buf: directed and random captures against a sample-list model.
module tb_trigger_capture_buf;
    import trigger_pkg::*;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned ADDR_W = 9;
    localparam int          NSAMP  = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              arm = 1'b0;
    logic [1:0]        trig_mode = 2'b00;
    logic [DATA_W-1:0] trig_level = '0;
    logic [ADDR_W-1:0] pretrig = '0;
    logic              ready, busy, triggered, auto_trig;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [DATA_W-1:0] samp [NSAMP];

    always #5 clk = ~clk;

    trigger_capture_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
`ifdef AUTO_TRIG_EN
        ,
        .AUTO_TMO (64)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .pretrig    (pretrig),
        .ready      (ready),
        .busy       (busy),
        .triggered  (triggered),
        .auto_trig  (auto_trig),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Index of the trigger sample in the post-arm valid-sample list, or -1.
    function automatic int find_trig(trig_mode_t m, logic [DATA_W-1:0] lvl, int p);
        bit r, f;
        for (int k = p; k < NSAMP; k++) begin
            if (m == TRIG_FORCE) return k;
            if (k > 0) begin
                r = (samp[k-1] <  lvl) && (samp[k] >= lvl);
                f = (samp[k-1] >= lvl) && (samp[k] <  lvl);
                if ((m == TRIG_RISE && r) || (m == TRIG_FALL && f) || (m == TRIG_EDGE && (r || f)))
                    return k;
            end
        end
        return -1;
    endfunction

    task automatic rd(input int a, output logic [DATA_W-1:0] d);
        rd_addr = a[ADDR_W-1:0];
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic capture(input string tag, input trig_mode_t m, input logic [DATA_W-1:0] lvl,
                           input int p, input int period, input bit arm_valid, input bit arm_in_post);
        int t, need, idx, cyc;
        bit done, poked;
        logic [DATA_W-1:0] d;
        t    = find_trig(m, lvl, p);
        need = t + DEPTH - p;
        @(negedge clk);
        trig_mode  = m;
        trig_level = lvl;
        pretrig    = p[ADDR_W-1:0];
        arm        = 1'b1;
        s_valid    = arm_valid;
        s_data     = ~samp[0];
        @(negedge clk);
        arm     = 1'b0;
        s_valid = 1'b0;
        chk({tag, " busy_after_arm"}, 32'(busy), 1);
        chk({tag, " trig_clr_after_arm"}, 32'(triggered), 0);
        idx = 0; cyc = 0; done = 0; poked = 0;
        while (!done && cyc < 20000) begin
            if (ready) begin
                done = 1;
            end else begin
                arm = 1'b0;
                if (arm_in_post && !poked && triggered && busy) begin
                    arm   = 1'b1;
                    poked = 1;
                end
                s_valid = ((cyc % period) == 0) && (idx < NSAMP);
                if (s_valid) begin
                    s_data = samp[idx];
                    idx++;
                end else begin
                    s_data = DATA_W'($urandom);
                end
                cyc++;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        arm     = 1'b0;
        chk({tag, " reached_done"}, 32'(done), 1);
        chk({tag, " samples_used"}, 32'(idx), 32'(need));
        chk({tag, " done_cycles"}, 32'(cyc), 32'((need - 1) * period + 1));
        chk({tag, " triggered"}, 32'(triggered), 1);
        chk({tag, " busy_done"}, 32'(busy), 0);
        chk({tag, " auto_trig"}, 32'(auto_trig), 0);
        if (arm_in_post) chk({tag, " post_arm_poked"}, 32'(poked), 1);
        for (int a = 0; a < int'(DEPTH); a++) begin
            rd(a, d);
            chk($sformatf("%s rd[%0d]", tag, a), 32'(d), 32'(samp[t - p + a]));
        end
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        trig_mode_t        m;
        logic [DATA_W-1:0] lvl;
        int                p, t;

        repeat (3) @(negedge clk);
        chk("rst ready", 32'(ready), 1);
        chk("rst busy", 32'(busy), 0);
        chk("rst triggered", 32'(triggered), 0);
        chk("rst auto_trig", 32'(auto_trig), 0);
        chk("rst rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        @(negedge clk);

`ifndef AUTO_TRIG_EN
        for (int i = 0; i < NSAMP; i++) samp[i] = DATA_W'(i * 8);
        capture("ramp_rise", TRIG_RISE, 12'd2048, 100, 1, 0, 0);
        rd(100, d); chk("ramp rd100", 32'(d), 2048);
        rd(0, d);   chk("ramp rd0", 32'(d), 1248);
        rd(511, d); chk("ramp rd511", 32'(d), (2048 + 411 * 8) % 4096);

        capture("ramp_rise_div3", TRIG_RISE, 12'd2048, 100, 3, 0, 0);
        rd(100, d); chk("div3 rd100", 32'(d), 2048);

        capture("ramp_post_arm", TRIG_RISE, 12'd2048, 100, 1, 0, 1);

        for (int i = 0; i < NSAMP; i++) samp[i] = DATA_W'(4095 - i * 8);
        capture("ramp_fall", TRIG_FALL, 12'd2048, 0, 1, 0, 0);
        rd(0, d); chk("fall rd0", 32'(d), 2047);

        for (int i = 0; i < NSAMP; i++) samp[i] = DATA_W'($urandom);
        capture("force_p511", TRIG_FORCE, 12'd0, 511, 1, 0, 0);
        capture("arm_with_valid", TRIG_FORCE, 12'd0, 10, 1, 1, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NSAMP; i++) samp[i] = DATA_W'($urandom);
            m   = trig_mode_t'($urandom_range(0, 3));
            lvl = DATA_W'($urandom_range(512, 3583));
            p   = int'($urandom_range(0, DEPTH - 1));
            t   = find_trig(m, lvl, p);
            if (t < 0 || t + int'(DEPTH) - p > NSAMP) m = TRIG_FORCE;
            capture($sformatf("rand%0d", r), m, lvl, p, int'($urandom_range(1, 3)), r[0], 0);
        end
`else
        for (int i = 0; i < NSAMP; i++) samp[i] = 12'd1000;
        @(negedge clk);
        trig_mode = TRIG_RISE; trig_level = 12'd2000; pretrig = '0; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        s_valid = 1'b1; s_data = 12'd1000;
        repeat (40) @(negedge clk);
        chk("auto not_yet", 32'(triggered), 0);
        begin
            int cyc;
            cyc = 0;
            while (!ready && cyc < 5000) begin
                @(negedge clk);
                cyc++;
            end
            chk("auto reached_done", 32'(ready), 1);
        end
        s_valid = 1'b0;
        chk("auto auto_trig", 32'(auto_trig), 1);
        chk("auto triggered", 32'(triggered), 1);
        rd(0, d); chk("auto rd0", 32'(d), 1000);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("auto cleared_on_arm", 32'(auto_trig), 0);
`endif

        // abort in WAIT_TRIG
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        trig_mode = TRIG_RISE; trig_level = 12'd4000; pretrig = '0; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0; s_valid = 1'b1; s_data = 12'd100;
        repeat (20) @(negedge clk);
        chk("wait busy", 32'(busy), 1);
        chk("wait triggered", 32'(triggered), 0);
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait ready", 32'(ready), 1);
        chk("rst_wait busy", 32'(busy), 0);
        chk("rst_wait triggered", 32'(triggered), 0);

        // abort in POST with trigger already seen
        trig_mode = TRIG_FORCE; pretrig = '0; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0; s_valid = 1'b1; s_data = 12'd7;
        repeat (10) @(negedge clk);
        chk("post busy", 32'(busy), 1);
        chk("post triggered", 32'(triggered), 1);
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_post ready", 32'(ready), 1);
        chk("rst_post triggered", 32'(triggered), 0);
        chk("rst_post auto_trig", 32'(auto_trig), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
